adc083000_ctrl_seq: RTL and testbench
=====================================

// Module: adc083000_ctrl_seq
// PURPOSE
//  Control sequencer for the ADC083000 board PHY. Owns the DCM reset line (ctrl_reset) and sequences
//  DCM reset/lock at power-up and on request, and serialises single-register writes to the ADC 3-wire
//  config port. Sits between the software register block and adc083000_board_phy/ADC pins.
//  One engine serves both jobs; recal and config writes are mutually exclusive.
// PARAMETERS
//  CLK_DIV       4      clk cycles per SCLK half-period (>=2)
//  GAP_CYCLES    8      clk cycles SCS_n held high after each frame before ack (>=1)
//  RST_CYCLES    16     clk cycles ctrl_reset asserted per recal (>=3, covers DCM min reset)
//  LOCK_TIMEOUT  65535  clk cycles to wait for synchronised lock before flagging error
// PORTS
//  clk            in   1   control clock; all logic on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  cfg_req        in   1   write request; accepted on cycle cfg_req & ~cfg_busy
//  cfg_addr       in   4   ADC register address, captured on accept
//  cfg_data       in   16  ADC register data, captured on accept
//  cfg_busy       out  1   engine busy (frame, gap, or recal in progress)
//  cfg_ack        out  1   1-cycle pulse: frame and gap complete
//  recal_req      in   1   request DCM reset + relock; accepted when ~cfg_busy
//  adc_scs_n      out  1   ADC serial chip select, active low
//  adc_sclk       out  1   ADC serial clock
//  adc_sdata      out  1   ADC serial data, MSB first
//  ctrl_reset     out  1   DCM reset to PHY, active high
//  adc_dcm_locked in   1   DCM LOCKED from PHY (async; 2-FF synchronised internally)
//  phy_ready      out  1   DCM locked and no recal in progress
//  lock_err       out  1   sticky: last recal timed out; cleared when next recal starts
// BEHAVIOUR
//  Reset (reset_n=0): scs_n=1, sclk=0, sdata=0, ctrl_reset=1, busy=1, ack=0, phy_ready=0, lock_err=0.
//  After reset_n rises, FSM enters RST_PULSE automatically (power-up recal).
//  States: IDLE, SHIFT, GAP, RST_PULSE, WAIT_LOCK.
//  IDLE: busy=0. recal_req -> RST_PULSE. cfg_req -> SHIFT. Both high same cycle: recal wins; cfg_req
//   not accepted that cycle (requester keeps it high to retry).
//  Frame: 32 bits = {12'h001 header, addr[3:0], data[15:0]}, MSB first.
//  Accept at cycle T0. From T0+1: scs_n=0, sclk=0, sdata=bit31. sclk toggles every CLK_DIV cycles
//   (first rise T0+1+CLK_DIV). sdata changes only on sclk falling edge; ADC samples on rising.
//  After 32 full SCLK periods (T0+1+64*CLK_DIV): scs_n=1, sclk=0, sdata=0, enter GAP.
//  GAP: GAP_CYCLES cycles, then ack=1 for one cycle, same cycle busy=0 and state=IDLE;
//   a new cfg_req can be accepted in the ack cycle. Latency accept->ack = 1+64*CLK_DIV+GAP_CYCLES.
//  recal_req/cfg_req while busy: ignored (no queueing).
//  RST_PULSE: ctrl_reset=1, phy_ready=0, lock_err cleared; RST_CYCLES cycles -> WAIT_LOCK.
//  WAIT_LOCK: ctrl_reset=0; counter from 0. locked_sync=1 -> phy_ready=1, IDLE. Counter reaches
//   LOCK_TIMEOUT -> lock_err=1, phy_ready=0, IDLE (no auto retry).
//  In IDLE, phy_ready follows locked_sync (lock loss drops phy_ready in <=3 cycles; no auto recal).
//  Counters sized $clog2 of their max; no wrap: each counter clears on state entry.
//  Async reset mid-frame: scs_n rises immediately, aborting the frame (ADC discards it);
//   ctrl_reset reasserts.
// STRUCTURE
//  Package adc083000_ctrl_pkg: state encoding, FRAME_BITS=32, HEADER=12'h001, frame-pack function.
//  Sub-module adc083000_spi_tx: 32-bit shift register + SCLK divider (start/done), instanced once;
//   FSM, lock synchroniser, timeout counter stay in the top.
// TESTING
//  Power-up: release reset_n, lock rises 100 cycles later -> ctrl_reset high 16 cycles, phy_ready=1
//   by 3 cycles after lock.
//  Write addr=4'h1 data=16'hB2FF, CLK_DIV=4: 32 rising sclk edges, sampled bits = 32'h0011B2FF,
//   ack exactly 1+256+8 cycles after accept.
//  cfg_req held high: two back-to-back frames, second accepted in first ack cycle, scs_n high >=8 cycles.
//  recal_req and cfg_req same IDLE cycle -> recal runs first, frame starts in cycle after relock.
//  Lock never asserts, LOCK_TIMEOUT=100 -> lock_err=1, phy_ready=0; next recal clears lock_err.
//  reset_n low at bit 10 of a frame -> scs_n=1, sclk=0 same cycle, ctrl_reset=1, no ack ever.

Source files
------------

// File: rtl/adc083000_ctrl_pkg.sv
// rtl/adc083000_ctrl_pkg.sv - shared types, frame constants and frame packing for the ADC083000 control sequencer
package adc083000_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_RST_PULSE,
    ST_WAIT_LOCK
  } state_t;

  localparam int          FRAME_BITS = 32;
  localparam logic [11:0] HEADER     = 12'h001;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [3:0]  addr,
                                                       input logic [15:0] data);
    return {HEADER, addr, data};
  endfunction

endpackage

// File: rtl/adc083000_spi_tx.sv
// rtl/adc083000_spi_tx.sv - 32-bit MSB-first shifter with SCLK divider for the ADC 3-wire config port
module adc083000_spi_tx
  import adc083000_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  done,
  output logic                  scs_n,
  output logic                  sclk,
  output logic                  sdata
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * FRAME_BITS);

  logic [FRAME_BITS-1:0] shreg;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic                  active;
  logic                  tick;

  // sdata is the register MSB, so it can only move when shreg moves (on SCLK falls)
  assign sdata = shreg[FRAME_BITS-1];
  assign tick  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done  = tick && (half_cnt == HALF_W'(2 * FRAME_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
      active   <= 1'b0;
      scs_n    <= 1'b1;
      sclk     <= 1'b0;
    end else if (start) begin
      shreg    <= frame;
      div_cnt  <= '0;
      half_cnt <= '0;
      active   <= 1'b1;
      scs_n    <= 1'b0;
      sclk     <= 1'b0;
    end else if (active) begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        half_cnt <= half_cnt + HALF_W'(1);
        if (done) begin
          active <= 1'b0;
          scs_n  <= 1'b1;
          sclk   <= 1'b0;
          shreg  <= '0;
        end else begin
          sclk <= ~sclk;
          if (sclk) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/adc083000_ctrl_seq.sv
// rtl/adc083000_ctrl_seq.sv - DCM reset/relock sequencer and serialised ADC register writer sharing one engine
module adc083000_ctrl_seq
  import adc083000_ctrl_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_req,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        cfg_busy,
  output logic        cfg_ack,
  input  logic        recal_req,
  output logic        adc_scs_n,
  output logic        adc_sclk,
  output logic        adc_sdata,
  output logic        ctrl_reset,
  input  logic        adc_dcm_locked,
  output logic        phy_ready,
  output logic        lock_err
);
  localparam int MAX_RG  = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_RG) ? LOCK_TIMEOUT : MAX_RG;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  lock_meta;
  logic                  locked_sync;
  logic                  tx_start;
  logic                  tx_done;
  logic [FRAME_BITS-1:0] frame;

  // recal has priority; a simultaneous cfg_req is simply not accepted this cycle
  assign tx_start = (state == ST_IDLE) && cfg_req && !recal_req;
  assign frame    = pack_frame(cfg_addr, cfg_data);

  adc083000_spi_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_spi_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (tx_start),
    .frame  (frame),
    .done   (tx_done),
    .scs_n  (adc_scs_n),
    .sclk   (adc_sclk),
    .sdata  (adc_sdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta   <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      lock_meta   <= adc_dcm_locked;
      locked_sync <= lock_meta;
    end
  end

  // Reset lands directly in RST_PULSE so power-up recal needs no request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RST_PULSE;
      cnt        <= '0;
      cfg_busy   <= 1'b1;
      cfg_ack    <= 1'b0;
      ctrl_reset <= 1'b1;
      phy_ready  <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          phy_ready <= locked_sync;
          if (recal_req) begin
            state      <= ST_RST_PULSE;
            cnt        <= '0;
            cfg_busy   <= 1'b1;
            ctrl_reset <= 1'b1;
            phy_ready  <= 1'b0;
            lock_err   <= 1'b0;
          end else if (cfg_req) begin
            state    <= ST_SHIFT;
            cfg_busy <= 1'b1;
          end
        end
        ST_SHIFT: begin
          phy_ready <= locked_sync;
          if (tx_done) begin
            state <= ST_GAP;
            cnt   <= '0;
          end
        end
        ST_GAP: begin
          phy_ready <= locked_sync;
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state    <= ST_IDLE;
            cfg_busy <= 1'b0;
            cfg_ack  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RST_PULSE: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            ctrl_reset <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_sync) begin
            state     <= ST_IDLE;
            cfg_busy  <= 1'b0;
            phy_ready <= 1'b1;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state     <= ST_IDLE;
            cfg_busy  <= 1'b0;
            phy_ready <= 1'b0;
            lock_err  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc083000_ctrl_seq.sv
// tb/tb_adc083000_ctrl_seq.sv - randomized self-checking bench for adc083000_ctrl_seq with a DCM and SPI-decoding model
module tb_adc083000_ctrl_seq;
  localparam int CLK_DIV      = 4;
  localparam int GAP_CYCLES   = 8;
  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LATENCY      = 1 + 64 * CLK_DIV + GAP_CYCLES;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        recal_req = 1'b0;
  logic        adc_dcm_locked = 1'b0;
  logic        cfg_busy, cfg_ack, adc_scs_n, adc_sclk, adc_sdata, ctrl_reset, phy_ready, lock_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  adc083000_ctrl_seq #(
    .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .recal_req(recal_req), .adc_scs_n(adc_scs_n),
    .adc_sclk(adc_sclk), .adc_sdata(adc_sdata), .ctrl_reset(ctrl_reset),
    .adc_dcm_locked(adc_dcm_locked), .phy_ready(phy_ready), .lock_err(lock_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DCM model: lock drops while held in reset, returns lock_after cycles after release
  int lock_after = 84;
  bit dcm_dead = 1'b0;
  int lcnt = 0;
  always @(posedge clk) begin
    if (ctrl_reset || dcm_dead) begin
      adc_dcm_locked <= 1'b0;
      lcnt <= 0;
    end else if (lcnt >= lock_after) begin
      adc_dcm_locked <= 1'b1;
    end else begin
      lcnt <= lcnt + 1;
    end
  end

  // ADC-side decoder: samples sdata on SCLK rises, collects each completed frame
  logic [31:0] sh = '0;
  int rises = 0, hi_run = 0, last_gap = 0, sdata_viol = 0, ack_viol = 0, ack_cnt = 0;
  logic p_scs = 1'b1, p_sclk = 1'b0, p_sdata = 1'b0, p_ack = 1'b0;
  logic [31:0] obs_q[$];
  int rise_q[$];
  always @(negedge clk) begin
    p_scs <= adc_scs_n;
    p_sclk <= adc_sclk;
    p_sdata <= adc_sdata;
    p_ack <= cfg_ack;
    if (!reset_n) begin
      rises <= 0;
      hi_run <= 0;
    end else begin
      if (!adc_scs_n && adc_sclk && !p_sclk) begin
        sh <= {sh[30:0], adc_sdata};
        rises <= rises + 1;
      end
      if (!adc_scs_n && !p_scs && (adc_sdata != p_sdata) && !(p_sclk && !adc_sclk))
        sdata_viol <= sdata_viol + 1;
      if (adc_scs_n && !p_scs) begin
        obs_q.push_back(sh);
        rise_q.push_back(rises);
        rises <= 0;
      end
      if (adc_scs_n) hi_run <= hi_run + 1;
      else if (p_scs) begin
        last_gap <= hi_run;
        hi_run <= 0;
      end
      if (cfg_ack) ack_cnt <= ack_cnt + 1;
      if (cfg_ack && (p_ack || cfg_busy)) ack_viol <= ack_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int k);
    int n = 0;
    @(negedge clk);
    while (!cfg_ack && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", cfg_ack, 1);
    k = cyc;
  endtask

  task automatic check_frame(input logic [31:0] w);
    if (obs_q.size() == 0) check("frame_seen", 0, 1);
    else begin
      check("frame_bits", obs_q.pop_front(), w);
      check("sclk_rises", rise_q.pop_front(), 32);
    end
  endtask

  task automatic finish_frame(input int d, input logic [31:0] w);
    int k;
    wait_ack(k);
    check("ack_latency", k - d, LATENCY);
    check_frame(w);
  endtask

  task automatic start_write(input logic [3:0] a, input logic [15:0] dt, output int d);
    int n = 0;
    logic [31:0] w;
    w = {12'h001, a, dt};
    while (cfg_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_write", cfg_busy, 0);
    cfg_req = 1'b1;
    cfg_addr = a;
    cfg_data = dt;
    d = cyc;
    @(negedge clk);
    cfg_req = 1'b0;
    check("busy_after_accept", cfg_busy, 1);
    check("scs_low_after_accept", adc_scs_n, 0);
    check("first_bit", adc_sdata, w[31]);
  endtask

  task automatic wait_lock_ready(input string tag);
    int n = 0;
    int t_lock;
    int scs_low = 0;
    while (!adc_dcm_locked && n < 2000) begin
      @(negedge clk);
      n++;
      if (!adc_scs_n) scs_low++;
    end
    t_lock = cyc;
    n = 0;
    while (!phy_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_within_3"}, phy_ready && (cyc - t_lock <= 3), 1);
    check({tag, "_scs_quiet"}, scs_low, 0);
    check({tag, "_idle"}, cfg_busy, 0);
    check({tag, "_lock_err"}, lock_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, d2, k, n, ackc;
    logic [3:0] a, a2;
    logic [15:0] dt, dt2;

    repeat (3) @(negedge clk);
    check("rst_scs_n", adc_scs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_sdata", adc_sdata, 0);
    check("rst_ctrl_reset", ctrl_reset, 1);
    check("rst_busy", cfg_busy, 1);
    check("rst_ack", cfg_ack, 0);
    check("rst_phy_ready", phy_ready, 0);
    check("rst_lock_err", lock_err, 0);

    reset_n = 1'b1;
    n = 0;
    while (ctrl_reset && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("powerup_reset_len", n, RST_CYCLES);
    wait_lock_ready("powerup");

    start_write(4'h1, 16'hB2FF, d);
    finish_frame(d, 32'h0011B2FF);

    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom);
      dt = 16'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      start_write(a, dt, d);
      repeat ($urandom_range(20, 200)) @(negedge clk);
      cfg_req = 1'b1;
      cfg_addr = ~a;
      recal_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
      recal_req = 1'b0;
      finish_frame(d, {12'h001, a, dt});
      check("busy_ignores_recal", ctrl_reset, 0);
      check("busy_keeps_ready", phy_ready, 1);
    end

    a = 4'($urandom);
    dt = 16'($urandom);
    a2 = 4'($urandom);
    dt2 = 16'($urandom);
    check("b2b_idle", cfg_busy, 0);
    cfg_req = 1'b1;
    cfg_addr = a;
    cfg_data = dt;
    d = cyc;
    @(negedge clk);
    cfg_addr = a2;
    cfg_data = dt2;
    wait_ack(k);
    check("b2b_first_latency", k - d, LATENCY);
    d2 = k;
    @(negedge clk);
    cfg_req = 1'b0;
    check("b2b_second_accepted", cfg_busy, 1);
    check("b2b_second_scs", adc_scs_n, 0);
    check_frame({12'h001, a, dt});
    finish_frame(d2, {12'h001, a2, dt2});
    check("b2b_gap", last_gap >= GAP_CYCLES, 1);

    lock_after = $urandom_range(5, 40);
    a = 4'($urandom);
    dt = 16'($urandom);
    recal_req = 1'b1;
    cfg_req = 1'b1;
    cfg_addr = a;
    cfg_data = dt;
    @(negedge clk);
    recal_req = 1'b0;
    check("recal_wins_ctrl_reset", ctrl_reset, 1);
    check("recal_wins_scs", adc_scs_n, 1);
    check("recal_drops_ready", phy_ready, 0);
    n = 0;
    while (ctrl_reset && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("recal_reset_len", n, RST_CYCLES);
    wait_lock_ready("relock");
    d = cyc;
    @(negedge clk);
    cfg_req = 1'b0;
    check("frame_after_relock", adc_scs_n, 0);
    finish_frame(d, {12'h001, a, dt});

    dcm_dead = 1'b1;
    repeat (4) @(negedge clk);
    check("lockloss_phy_ready", phy_ready, 0);
    check("lockloss_no_auto_recal", ctrl_reset, 0);
    recal_req = 1'b1;
    @(negedge clk);
    recal_req = 1'b0;
    repeat (RST_CYCLES + LOCK_TIMEOUT / 2) @(negedge clk);
    check("timeout_not_yet", lock_err, 0);
    check("timeout_still_busy", cfg_busy, 1);
    repeat (LOCK_TIMEOUT / 2 + 5) @(negedge clk);
    check("timeout_lock_err", lock_err, 1);
    check("timeout_phy_ready", phy_ready, 0);
    check("timeout_idle", cfg_busy, 0);
    repeat (50) @(negedge clk);
    check("timeout_no_retry", ctrl_reset, 0);
    check("timeout_err_sticky", lock_err, 1);
    dcm_dead = 1'b0;
    recal_req = 1'b1;
    @(negedge clk);
    recal_req = 1'b0;
    check("lock_err_cleared", lock_err, 0);
    wait_lock_ready("recover");

    a = 4'($urandom);
    dt = 16'($urandom);
    start_write(a, dt, d);
    n = 0;
    while (rises < 10 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_bit10", rises >= 10, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_scs_n", adc_scs_n, 1);
    check("abort_sclk", adc_sclk, 0);
    check("abort_ctrl_reset", ctrl_reset, 1);
    check("abort_busy", cfg_busy, 1);
    ackc = ack_cnt;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    wait_lock_ready("post_abort");
    repeat (LATENCY + 20) @(negedge clk);
    check("abort_no_ack", ack_cnt, ackc);

    check("sdata_edge_rule", sdata_viol, 0);
    check("ack_pulse_shape", ack_viol, 0);
    check("leftover_frames", obs_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
